// File: rtl/traffic_phase_ctrl.sv
// traffic_phase_ctrl
// Phase sequencer for a two-direction (north-south / east-west) intersection.
// A prescaler divides clk down to a one-second tick. The controller counts
// down the seconds left in each green/yellow/red phase. A flashing-yellow
// night mode takes priority over everything else.
//
// Ports:
//   clk      - system clock, rising edge
//   rst      - asynchronous, active-high reset
//   en       - run enable; 0 freezes the normal cycle (night mode keeps running)
//   night    - level; 1 selects flashing-yellow night mode
//   cnt_d    - seconds left in the current phase, 0 in night mode
//   light_ns - north-south lamps {red,yellow,green}
//   light_ew - east-west lamps {red,yellow,green}
//   sec_tick - one-cycle pulse per elapsed second
module traffic_phase_ctrl #(
  parameter int unsigned DIV      = 50_000_000,
  parameter int unsigned T_GREEN  = 25,
  parameter int unsigned T_YELLOW = 3,
  parameter int unsigned T_ALLRED = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       night,
  output logic [4:0] cnt_d,
  output logic [2:0] light_ns,
  output logic [2:0] light_ew,
  output logic       sec_tick
);

  if (DIV < 2 || T_GREEN < 1 || T_GREEN > 31 || T_YELLOW < 1 || T_YELLOW > 31 ||
      T_ALLRED < 1 || T_ALLRED > 31) begin : g_param_check
    $error("traffic_phase_ctrl: parameter out of range");
  end

  localparam int unsigned PW = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] PMAX = PW'(DIV - 1);
  localparam logic [4:0] TG = 5'(T_GREEN);
  localparam logic [4:0] TY = 5'(T_YELLOW);
  localparam logic [4:0] TR = 5'(T_ALLRED);

  localparam logic [2:0] RED    = 3'b100;
  localparam logic [2:0] YELLOW = 3'b010;
  localparam logic [2:0] GREEN  = 3'b001;

  typedef enum logic [2:0] {
    NS_GREEN  = 3'd0,
    NS_YELLOW = 3'd1,
    EW_GREEN  = 3'd2,
    EW_YELLOW = 3'd3,
    ALL_RED   = 3'd4,
    NIGHT     = 3'd5
  } state_t;

  state_t        state, state_next;
  logic [PW-1:0] presc, presc_next;
  logic          flash, flash_next;
  logic          tick_next;
  logic [4:0]    cnt_next;
  logic [2:0]    ns_next, ew_next;
  logic          running, advance;

  // Every output, and all other state, is held in a register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= NS_GREEN;
      cnt_d    <= TG;
      presc    <= '0;
      sec_tick <= 1'b0;
      flash    <= 1'b0;
      light_ns <= GREEN;
      light_ew <= RED;
    end else begin
      state    <= state_next;
      cnt_d    <= cnt_next;
      presc    <= presc_next;
      sec_tick <= tick_next;
      flash    <= flash_next;
      light_ns <= ns_next;
      light_ew <= ew_next;
    end
  end

  // Next-state logic for the prescaler, the phase FSM and the lamps.
  always_comb begin
    state_next = state;
    cnt_next   = cnt_d;
    presc_next = presc;
    flash_next = flash;
    tick_next  = 1'b0;
    ns_next    = RED;
    ew_next    = RED;

    // Night mode ignores en, so the lamps keep flashing while the cycle is paused.
    running = en || (state == NIGHT);
    // A tick that is still pending when en drops is not used, so a pause freezes the phase.
    advance = sec_tick && en;

    if (running) begin
      if (presc == PMAX) begin
        presc_next = '0;
        tick_next  = 1'b1;
      end else begin
        presc_next = presc + PW'(1);
      end
    end

    if (night) begin
      state_next = NIGHT;
      if (state != NIGHT) begin
        // Entering night mode restarts the second so the first flash lasts a full second.
        cnt_next   = 5'd0;
        flash_next = 1'b1;
        presc_next = '0;
        tick_next  = 1'b0;
      end else if (sec_tick) begin
        flash_next = ~flash;
      end
    end else begin
      unique case (state)
        NIGHT: begin
          state_next = ALL_RED;
          cnt_next   = TR;
          presc_next = '0;
          tick_next  = 1'b0;
          flash_next = 1'b0;
        end
        NS_GREEN, NS_YELLOW, EW_GREEN, EW_YELLOW, ALL_RED: begin
          if (advance) begin
            if (cnt_d > 5'd1) begin
              cnt_next = cnt_d - 5'd1;
            end else begin
              unique case (state)
                NS_GREEN:  begin state_next = NS_YELLOW; cnt_next = TY; end
                NS_YELLOW: begin state_next = EW_GREEN;  cnt_next = TG; end
                EW_GREEN:  begin state_next = EW_YELLOW; cnt_next = TY; end
                default:   begin state_next = NS_GREEN;  cnt_next = TG; end
              endcase
            end
          end
        end
        default: begin
          // Unreachable encodings go to a safe all-red phase.
          state_next = ALL_RED;
          cnt_next   = TR;
        end
      endcase
    end

    // The lamps are decoded from the next state, so they change on the same edge as the state.
    case (state_next)
      NS_GREEN:  begin ns_next = GREEN;  ew_next = RED;    end
      NS_YELLOW: begin ns_next = YELLOW; ew_next = RED;    end
      EW_GREEN:  begin ns_next = RED;    ew_next = GREEN;  end
      EW_YELLOW: begin ns_next = RED;    ew_next = YELLOW; end
      NIGHT: begin
        ns_next = {1'b0, flash_next, 1'b0};
        ew_next = {1'b0, flash_next, 1'b0};
      end
      default:   begin ns_next = RED;    ew_next = RED;    end
    endcase
  end

endmodule

// File: tb/tb_traffic_phase_ctrl.sv
// tb_traffic_phase_ctrl
// Directed testbench for traffic_phase_ctrl with DIV=4, T_GREEN=5, T_YELLOW=2, T_ALLRED=2.
// Inputs are driven and outputs are sampled on the falling edge of clk.
module tb_traffic_phase_ctrl;

  logic       clk;
  logic       rst;
  logic       en;
  logic       night;
  logic [4:0] cnt_d;
  logic [2:0] light_ns;
  logic [2:0] light_ew;
  logic       sec_tick;

  int vectors;
  int miscompares;

  traffic_phase_ctrl #(
    .DIV(4),
    .T_GREEN(5),
    .T_YELLOW(2),
    .T_ALLRED(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .en(en),
    .night(night),
    .cnt_d(cnt_d),
    .light_ns(light_ns),
    .light_ew(light_ew),
    .sec_tick(sec_tick)
  );

  // Free-running clock with a 10-time-unit period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // On every cycle, checks that both directions never show green at once.
  always @(negedge clk) begin
    vectors++;
    assert (!(light_ns === 3'b001 && light_ew === 3'b001)) else begin
      miscompares++;
      $error("[TB] FAIL both_green light_ns=%b light_ew=%b required not both 001", light_ns, light_ew);
    end
  end

  // Drives the inputs, then waits the given number of falling edges.
  task automatic apply_stimulus(input logic r, input logic e, input logic n, input int cycles);
    rst   = r;
    en    = e;
    night = n;
    repeat (cycles) @(negedge clk);
  endtask

  // Compares all outputs against hand-computed values.
  task automatic check_output(input string tag, input logic [4:0] exp_cnt,
                              input logic [2:0] exp_ns, input logic [2:0] exp_ew,
                              input logic exp_tick);
    vectors++;
    assert (cnt_d === exp_cnt) else begin
      miscompares++;
      $error("[TB] FAIL %s cnt_d observed=%0d expected=%0d", tag, cnt_d, exp_cnt);
    end
    vectors++;
    assert (light_ns === exp_ns) else begin
      miscompares++;
      $error("[TB] FAIL %s light_ns observed=%b expected=%b", tag, light_ns, exp_ns);
    end
    vectors++;
    assert (light_ew === exp_ew) else begin
      miscompares++;
      $error("[TB] FAIL %s light_ew observed=%b expected=%b", tag, light_ew, exp_ew);
    end
    vectors++;
    assert (sec_tick === exp_tick) else begin
      miscompares++;
      $error("[TB] FAIL %s sec_tick observed=%b expected=%b", tag, sec_tick, exp_tick);
    end
  endtask

  // Directed sequence. The edge numbers in comments count rising edges after the first release of rst.
  initial begin
    vectors     = 0;
    miscompares = 0;
    rst   = 1'b1;
    en    = 1'b0;
    night = 1'b0;
    @(negedge clk);
    check_output("reset", 5'd5, 3'b001, 3'b100, 1'b0);

    // Normal cycle: ticks at edges 4, 8, ...; each phase change lands one edge after its tick.
    apply_stimulus(1'b0, 1'b1, 1'b0, 3);
    check_output("pre_tick", 5'd5, 3'b001, 3'b100, 1'b0);
    apply_stimulus(1'b0, 1'b1, 1'b0, 1);
    check_output("first_tick", 5'd5, 3'b001, 3'b100, 1'b1);
    apply_stimulus(1'b0, 1'b1, 1'b0, 1);
    check_output("first_dec", 5'd4, 3'b001, 3'b100, 1'b0);
    apply_stimulus(1'b0, 1'b1, 1'b0, 16);
    check_output("ns_yellow", 5'd2, 3'b010, 3'b100, 1'b0);
    apply_stimulus(1'b0, 1'b1, 1'b0, 8);
    check_output("ew_green", 5'd5, 3'b100, 3'b001, 1'b0);
    apply_stimulus(1'b0, 1'b1, 1'b0, 20);
    check_output("ew_yellow", 5'd2, 3'b100, 3'b010, 1'b0);
    apply_stimulus(1'b0, 1'b1, 1'b0, 8);
    check_output("ns_green_again", 5'd5, 3'b001, 3'b100, 1'b0);

    // Edge 66: prescaler=2, cnt_d=3. Pause for 20 clocks.
    apply_stimulus(1'b0, 1'b1, 1'b0, 9);
    check_output("pre_pause", 5'd3, 3'b001, 3'b100, 1'b0);
    for (int i = 0; i < 20; i++) begin
      apply_stimulus(1'b0, 1'b0, 1'b0, 1);
      check_output("paused", 5'd3, 3'b001, 3'b100, 1'b0);
    end
    apply_stimulus(1'b0, 1'b1, 1'b0, 1);
    check_output("resume_1", 5'd3, 3'b001, 3'b100, 1'b0);
    apply_stimulus(1'b0, 1'b1, 1'b0, 1);
    check_output("resume_tick", 5'd3, 3'b001, 3'b100, 1'b1);
    apply_stimulus(1'b0, 1'b1, 1'b0, 1);
    check_output("resume_dec", 5'd2, 3'b001, 3'b100, 1'b0);

    // Reach a tick during EW_GREEN, then raise night (en dropped as well).
    apply_stimulus(1'b0, 1'b1, 1'b0, 19);
    check_output("pre_night", 5'd5, 3'b100, 3'b001, 1'b1);
    apply_stimulus(1'b0, 1'b0, 1'b1, 1);
    check_output("night_entry", 5'd0, 3'b010, 3'b010, 1'b0);
    apply_stimulus(1'b0, 1'b0, 1'b1, 3);
    check_output("night_pre_tick", 5'd0, 3'b010, 3'b010, 1'b0);
    apply_stimulus(1'b0, 1'b0, 1'b1, 1);
    check_output("night_tick", 5'd0, 3'b010, 3'b010, 1'b1);
    apply_stimulus(1'b0, 1'b0, 1'b1, 1);
    check_output("night_flash_off", 5'd0, 3'b000, 3'b000, 1'b0);
    apply_stimulus(1'b0, 1'b0, 1'b1, 4);
    check_output("night_flash_on", 5'd0, 3'b010, 3'b010, 1'b0);

    // Night exit into ALL_RED, which stays frozen while en=0.
    apply_stimulus(1'b0, 1'b0, 1'b0, 1);
    check_output("allred_entry", 5'd2, 3'b100, 3'b100, 1'b0);
    apply_stimulus(1'b0, 1'b0, 1'b0, 6);
    check_output("allred_frozen", 5'd2, 3'b100, 3'b100, 1'b0);
    apply_stimulus(1'b0, 1'b1, 1'b0, 4);
    check_output("allred_tick", 5'd2, 3'b100, 3'b100, 1'b1);
    apply_stimulus(1'b0, 1'b1, 1'b0, 1);
    check_output("allred_dec", 5'd1, 3'b100, 3'b100, 1'b0);
    apply_stimulus(1'b0, 1'b1, 1'b0, 4);
    check_output("allred_to_green", 5'd5, 3'b001, 3'b100, 1'b0);

    // Assert rst between clock edges during NS_YELLOW.
    apply_stimulus(1'b0, 1'b1, 1'b0, 20);
    check_output("yellow_before_rst", 5'd2, 3'b010, 3'b100, 1'b0);
    #2 rst = 1'b1;
    #1 check_output("async_reset", 5'd5, 3'b001, 3'b100, 1'b0);
    @(negedge clk);
    check_output("reset_held", 5'd5, 3'b001, 3'b100, 1'b0);
    apply_stimulus(1'b0, 1'b1, 1'b0, 4);
    check_output("post_reset_tick", 5'd5, 3'b001, 3'b100, 1'b1);
    apply_stimulus(1'b0, 1'b1, 1'b0, 1);
    check_output("post_reset_dec", 5'd4, 3'b001, 3'b100, 1'b0);
    apply_stimulus(1'b0, 1'b1, 1'b0, 16);
    check_output("post_reset_yellow", 5'd2, 3'b010, 3'b100, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
